// File: rtl/nios2_oci_dct_packer.sv
// nios2_oci_dct_packer: packs 2-bit trace atoms into a 30-bit buffer and hands packets to the trace FIFO
// Optional cycle timestamp on packets: define NIOS2_OCI_DCT_TIMESTAMP_EN.
module nios2_oci_dct_packer #(
    parameter int ATOM_W    = 2,
    parameter int NUM_ATOMS = 15,
    parameter int DROP_W    = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        trace_enable,
    input  logic                        atom_valid,
    input  logic [ATOM_W-1:0]           atom_data,
    output logic                        atom_ready,
    input  logic                        flush,
    output logic [ATOM_W*NUM_ATOMS-1:0] dct_buffer,
    output logic [3:0]                  dct_count,
    output logic                        pkt_valid,
    input  logic                        pkt_ready,
    output logic [ATOM_W*NUM_ATOMS-1:0] pkt_data,
    output logic [3:0]                  pkt_count,
    output logic [15:0]                 pkt_timestamp,
    output logic                        overflow,
    input  logic                        overflow_clr,
    output logic [DROP_W-1:0]           drop_count
);
    localparam int BUF_W = ATOM_W * NUM_ATOMS;

    typedef enum logic [1:0] {DISABLED, FILL, DRAIN} state_t;

    state_t      state;
    logic        flush_pending;
    logic        out_free;
    logic        transfer;
    logic        accept;
    logic        drop;
    logic [3:0]  slot;
    logic [3:0]  next_count;
    logic [15:0] first_ts;

    // Handshake and accept/drop decisions; an atom arriving on a transfer cycle lands in slot 0
    always_comb begin
        out_free   = !pkt_valid || pkt_ready;
        transfer   = out_free && (dct_count == 4'(NUM_ATOMS) ||
                     ((flush_pending || state == DRAIN) && dct_count != 4'd0));
        atom_ready = state == FILL && (dct_count < 4'(NUM_ATOMS) || transfer);
        accept     = atom_valid && atom_ready;
        drop       = atom_valid && !atom_ready && state != DISABLED;
        slot       = transfer ? 4'd0 : dct_count;
        next_count = slot + {3'd0, accept};
    end

    // Accumulator: LSB-first packing, cleared when its contents move to the packet register
    always_ff @(posedge clk) begin
        if (reset) begin
            dct_buffer <= '0;
            dct_count  <= '0;
        end else begin
            dct_buffer <= (transfer ? '0 : dct_buffer) |
                          (accept ? BUF_W'(atom_data) << (ATOM_W * slot) : '0);
            dct_count  <= next_count;
        end
    end

    // Packet register: loads on transfer, holds until the FIFO takes it
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_valid     <= 1'b0;
            pkt_data      <= '0;
            pkt_count     <= '0;
            pkt_timestamp <= '0;
        end else if (transfer) begin
            pkt_valid     <= 1'b1;
            pkt_data      <= dct_buffer;
            pkt_count     <= dct_count;
            pkt_timestamp <= first_ts;
        end else if (pkt_ready) begin
            pkt_valid     <= 1'b0;
        end
    end

    // Pending flush survives until it produces a packet, or is dropped when there is nothing to send
    always_ff @(posedge clk) begin
        if (reset)
            flush_pending <= 1'b0;
        else
            flush_pending <= transfer ? 1'b0 : flush ? 1'b1 :
                             dct_count == 4'd0 ? 1'b0 : flush_pending;
    end

    // Sticky overflow and saturating drop counter; clear wins over a same-cycle drop
    always_ff @(posedge clk) begin
        if (reset || overflow_clr) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow   <= 1'b1;
            drop_count <= &drop_count ? drop_count : drop_count + 1'b1;
        end
    end

    // Capture sequencing: drain leftover atoms as a final packet when tracing stops
    always_ff @(posedge clk) begin
        if (reset)
            state <= DISABLED;
        else
            case (state)
                DISABLED: if (trace_enable) state <= FILL;
                FILL:     if (!trace_enable) state <= next_count != 4'd0 ? DRAIN : DISABLED;
                DRAIN:    if (trace_enable) state <= FILL;
                          else if (transfer) state <= DISABLED;
                default:  state <= DISABLED;
            endcase
    end

`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
    logic [15:0] cycle_ctr;

    // Free-running cycle counter; stamp latched when a packet's first atom lands
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_ctr <= '0;
            first_ts  <= '0;
        end else begin
            cycle_ctr <= cycle_ctr + 16'd1;
            if (accept && slot == 4'd0) first_ts <= cycle_ctr;
        end
    end
`else
    assign first_ts = '0;
`endif

endmodule
